// File: rtl/drum_timing.sv
// drum_timing: drum bit-time / word-time generator with revolution sync.
// Prescaler or single-step strobes advance T (0..28) and WT (0..107).
module drum_timing #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       RUN,
    input  logic       BIT_STEP,
    input  logic       SYNC_REQ,
    output logic       BIT_CE,
    output logic [4:0] T,
    output logic       T0,
    output logic       T28,
    output logic [6:0] WT,
    output logic       CE,
    output logic [1:0] WT4,
    output logic       ORIGIN,
    output logic       SYNC_ACK
);

    localparam logic [7:0] PRE_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ACK
    } sync_state_e;

    logic        rst_meta_q;
    logic        rst_sync_q;
    logic        rst_ni;

    logic [7:0]  pre_q, pre_d;
    logic        step_q, step_d;
    logic        step_dly_q, step_dly_d;
    logic        step_ce_q, step_ce_d;

    logic [4:0]  t_q, t_d;
    logic [6:0]  wt_q, wt_d;
    logic        t0_q, t0_d;
    logic        t28_q, t28_d;
    logic        ce_q, ce_d;
    logic [1:0]  wt4_q, wt4_d;
    logic        origin_q, origin_d;

    logic        bit_ce;
    logic        wrap;

    sync_state_e state_q;
    logic        sync_ack_q;

    // Reset asserts at once and releases two clocks after rst rises
    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign rst_ni = rst_sync_q;

    // Prescaler runs only with RUN; single-step edge detect otherwise
    always_comb begin
        pre_d = '0;
        if (RUN) begin
            pre_d = (pre_q == PRE_LAST) ? 8'd0 : pre_q + 8'd1;
        end
        step_d     = BIT_STEP;
        step_dly_d = step_q;
        step_ce_d  = !RUN && step_q && !step_dly_q;
    end

    assign bit_ce = (pre_q == PRE_LAST) || step_ce_q;
    assign wrap   = bit_ce && (t_q == 5'd28) && (wt_q == 7'd107);

    // Bit/word time advance; decodes come from the next-state values
    always_comb begin
        t_d  = t_q;
        wt_d = wt_q;
        if (bit_ce) begin
            if (t_q == 5'd28) begin
                t_d  = 5'd0;
                wt_d = (wt_q == 7'd107) ? 7'd0 : wt_q + 7'd1;
            end else begin
                t_d = t_q + 5'd1;
            end
        end
        t0_d     = (t_d == 5'd0);
        t28_d    = (t_d == 5'd28);
        ce_d     = ~wt_d[0];
        wt4_d    = wt_d[1:0];
        origin_d = (t_d == 5'd0) && (wt_d == 7'd0);
    end

    // Timing state registers
    always_ff @(posedge CLOCK or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q      <= '0;
            step_q     <= 1'b0;
            step_dly_q <= 1'b0;
            step_ce_q  <= 1'b0;
            t_q        <= '0;
            wt_q       <= '0;
            t0_q       <= 1'b1;
            t28_q      <= 1'b0;
            ce_q       <= 1'b1;
            wt4_q      <= '0;
            origin_q   <= 1'b1;
        end else begin
            pre_q      <= pre_d;
            step_q     <= step_d;
            step_dly_q <= step_dly_d;
            step_ce_q  <= step_ce_d;
            t_q        <= t_d;
            wt_q       <= wt_d;
            t0_q       <= t0_d;
            t28_q      <= t28_d;
            ce_q       <= ce_d;
            wt4_q      <= wt4_d;
            origin_q   <= origin_d;
        end
    end

    // Sync FSM: arm on request, grant on the end-of-revolution strobe
    always_ff @(posedge CLOCK or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            sync_ack_q <= 1'b0;
        end else begin
            sync_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (SYNC_REQ) state_q <= ARMED;
                end
                ARMED: begin
                    if (!SYNC_REQ) begin
                        state_q <= IDLE;
                    end else if (wrap) begin
                        state_q    <= ACK;
                        sync_ack_q <= 1'b1;
                    end
                end
                ACK: begin
                    if (!SYNC_REQ) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BIT_CE   = bit_ce;
    assign T        = t_q;
    assign T0       = t0_q;
    assign T28      = t28_q;
    assign WT       = wt_q;
    assign CE       = ce_q;
    assign WT4      = wt4_q;
    assign ORIGIN   = origin_q;
    assign SYNC_ACK = sync_ack_q;

endmodule
